// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates entries at issue, captures CDB results,
// retires completed entries in program order onto the register-file write port.
module reorder_buffer #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_valid,
    input  logic [4:0]       alloc_rd,
    input  logic             alloc_writes_rd,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    input  logic [TAG_W-1:0] q1_tag,
    output logic             q1_ready,
    output logic [31:0]      q1_data,
    input  logic [TAG_W-1:0] q2_tag,
    output logic             q2_ready,
    output logic [31:0]      q2_data,
    input  logic             flush,
    output logic             commit_valid,
    output logic [TAG_W-1:0] commit_tag,
    output logic [4:0]       commit_rd,
    output logic             commit_reg_write,
    output logic [31:0]      commit_data,
    output logic             empty,
    output logic [TAG_W:0]   count
);

    localparam logic [TAG_W:0] PTR_ONE = {{TAG_W{1'b0}}, 1'b1};

    logic [TAG_W:0]   head_r;
    logic [TAG_W:0]   tail_r;
    logic [DEPTH-1:0] valid_r;
    logic [DEPTH-1:0] done_r;
    logic [DEPTH-1:0] writes_rd_r;
    logic [4:0]       rd_r    [DEPTH];
    logic [31:0]      value_r [DEPTH];

    logic [TAG_W-1:0] head_idx_s;
    logic [TAG_W-1:0] tail_idx_s;
    logic             full_s;
    logic             alloc_fire_s;
    logic             commit_s;

    // Operand resolution: a same-cycle broadcast wins over the stored value.
    function automatic logic [32:0] resolve_operand(
        input logic        ent_valid,
        input logic        ent_done,
        input logic        bus_hit,
        input logic [31:0] stored,
        input logic [31:0] bus
    );
        logic [32:0] res;
        if (ent_valid && bus_hit) begin
            res = {1'b1, bus};
        end else if (ent_valid && ent_done) begin
            res = {1'b1, stored};
        end else begin
            res = {1'b0, 32'd0};
        end
        return res;
    endfunction

    assign head_idx_s   = head_r[TAG_W-1:0];
    assign tail_idx_s   = tail_r[TAG_W-1:0];
    assign full_s       = (head_idx_s == tail_idx_s) && (head_r[TAG_W] != tail_r[TAG_W]);
    assign empty        = (head_r == tail_r);
    assign count        = tail_r - head_r;
    assign alloc_ready  = !full_s;
    assign alloc_tag    = tail_idx_s;
    assign alloc_fire_s = alloc_valid && !full_s;
    assign commit_s     = valid_r[head_idx_s] && done_r[head_idx_s] && !flush;

    // Commit port driven from the head entry; all zero when nothing retires.
    always_comb begin
        commit_valid     = 1'b0;
        commit_tag       = {TAG_W{1'b0}};
        commit_rd        = 5'd0;
        commit_reg_write = 1'b0;
        commit_data      = 32'd0;
        if (commit_s) begin
            commit_valid     = 1'b1;
            commit_tag       = head_idx_s;
            commit_rd        = rd_r[head_idx_s];
            commit_reg_write = writes_rd_r[head_idx_s] && (rd_r[head_idx_s] != 5'd0);
            commit_data      = value_r[head_idx_s];
        end else begin
            commit_valid     = 1'b0;
        end
    end

    // Independent operand lookups for the two issue-stage source tags.
    always_comb begin
        {q1_ready, q1_data} = resolve_operand(valid_r[q1_tag], done_r[q1_tag],
                                              cdb_valid && (cdb_tag == q1_tag),
                                              value_r[q1_tag], cdb_data);
        {q2_ready, q2_data} = resolve_operand(valid_r[q2_tag], done_r[q2_tag],
                                              cdb_valid && (cdb_tag == q2_tag),
                                              value_r[q2_tag], cdb_data);
    end

    // Entry and pointer state; flush outranks alloc, capture and retirement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_r      <= {(TAG_W+1){1'b0}};
            tail_r      <= {(TAG_W+1){1'b0}};
            valid_r     <= {DEPTH{1'b0}};
            done_r      <= {DEPTH{1'b0}};
            writes_rd_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                rd_r[i]    <= 5'd0;
                value_r[i] <= 32'd0;
            end
        end else if (flush) begin
            head_r  <= {(TAG_W+1){1'b0}};
            tail_r  <= {(TAG_W+1){1'b0}};
            valid_r <= {DEPTH{1'b0}};
            done_r  <= {DEPTH{1'b0}};
        end else begin
            if (alloc_fire_s) begin
                valid_r[tail_idx_s]     <= 1'b1;
                done_r[tail_idx_s]      <= 1'b0;
                rd_r[tail_idx_s]        <= alloc_rd;
                writes_rd_r[tail_idx_s] <= alloc_writes_rd;
                tail_r                  <= tail_r + PTR_ONE;
            end
            if (cdb_valid && valid_r[cdb_tag]) begin
                done_r[cdb_tag]  <= 1'b1;
                value_r[cdb_tag] <= cdb_data;
            end
            if (commit_s) begin
                valid_r[head_idx_s] <= 1'b0;
                head_r              <= head_r + PTR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus random traffic
// compared against a program-order queue model of the in-flight instructions.
module tb_reorder_buffer;

    localparam int DEPTH = 16;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             alloc_valid;
    logic [4:0]       alloc_rd;
    logic             alloc_writes_rd;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;
    logic [TAG_W-1:0] q1_tag;
    logic             q1_ready;
    logic [31:0]      q1_data;
    logic [TAG_W-1:0] q2_tag;
    logic             q2_ready;
    logic [31:0]      q2_data;
    logic             flush;
    logic             commit_valid;
    logic [TAG_W-1:0] commit_tag;
    logic [4:0]       commit_rd;
    logic             commit_reg_write;
    logic [31:0]      commit_data;
    logic             empty;
    logic [TAG_W:0]   count;

    reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_writes_rd(alloc_writes_rd),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .q1_tag(q1_tag), .q1_ready(q1_ready), .q1_data(q1_data),
        .q2_tag(q2_tag), .q2_ready(q2_ready), .q2_data(q2_data),
        .flush(flush),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .commit_rd(commit_rd),
        .commit_reg_write(commit_reg_write), .commit_data(commit_data),
        .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [4:0]  rd;
        bit          wr;
        bit          done;
        logic [31:0] val;
    } ent_t;

    ent_t mq[$];
    int   m_head;
    int   n_cmp;
    int   n_mis;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] model_lookup(input int t, input bit cv, input int ct,
                                                 input logic [31:0] cd);
        logic [32:0] r;
        r = {1'b0, 32'd0};
        foreach (mq[i]) begin
            if (mq[i].tag == t) begin
                if (cv && ct == t)    r = {1'b1, cd};
                else if (mq[i].done)  r = {1'b1, mq[i].val};
                else                  r = {1'b0, 32'd0};
            end
        end
        return r;
    endfunction

    // One clock cycle: drive, compare every output against the model, advance the model.
    task automatic step(input bit av, input logic [4:0] ard, input bit awr,
                        input bit cv, input int ct, input logic [31:0] cd,
                        input int t1, input int t2, input bit fl);
        int          n;
        int          at;
        bit          cx;
        logic [32:0] l1;
        logic [32:0] l2;
        ent_t        e;
        @(negedge clk);
        alloc_valid = av; alloc_rd = ard; alloc_writes_rd = awr;
        cdb_valid = cv; cdb_tag = TAG_W'(ct); cdb_data = cd;
        q1_tag = TAG_W'(t1); q2_tag = TAG_W'(t2); flush = fl;
        #1;
        n  = mq.size();
        at = (m_head + n) % DEPTH;
        cx = (n > 0) && mq[0].done && !fl;
        check_val("empty", 64'(empty), 64'(n == 0));
        check_val("count", 64'(count), 64'(n));
        check_val("alloc_ready", 64'(alloc_ready), 64'(n < DEPTH));
        check_val("alloc_tag", 64'(alloc_tag), 64'(at));
        check_val("commit_valid", 64'(commit_valid), 64'(cx));
        if (cx) begin
            check_val("commit_tag", 64'(commit_tag), 64'(mq[0].tag));
            check_val("commit_rd", 64'(commit_rd), 64'(mq[0].rd));
            check_val("commit_reg_write", 64'(commit_reg_write), 64'(mq[0].wr && mq[0].rd != 5'd0));
            check_val("commit_data", 64'(commit_data), 64'(mq[0].val));
        end else begin
            check_val("commit_idle", {commit_data, 20'd0, commit_tag, commit_rd, commit_reg_write, 6'd0}, 64'd0);
        end
        l1 = model_lookup(t1, cv, ct, cd);
        l2 = model_lookup(t2, cv, ct, cd);
        check_val("q1", 64'({q1_ready, q1_data}), 64'(l1));
        check_val("q2", 64'({q2_ready, q2_data}), 64'(l2));
        if (fl) begin
            mq.delete();
            m_head = 0;
        end else begin
            if (cv) begin
                foreach (mq[i]) if (mq[i].tag == ct) begin
                    mq[i].done = 1'b1;
                    mq[i].val  = cd;
                end
            end
            if (cx) begin
                void'(mq.pop_front());
                m_head = (m_head + 1) % DEPTH;
            end
            if (av && n < DEPTH) begin
                e.tag = at; e.rd = ard; e.wr = awr; e.done = 1'b0; e.val = 32'd0;
                mq.push_back(e);
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 1'b0, 1'b0, 0, 32'd0, 0, 0, 1'b0);
    endtask

    task automatic alloc(input logic [4:0] rd, input bit wr);
        step(1'b1, rd, wr, 1'b0, 0, 32'd0, 0, 0, 1'b0);
    endtask

    task automatic cdb(input int t, input logic [31:0] d);
        step(1'b0, 5'd0, 1'b0, 1'b1, t, d, 0, 0, 1'b0);
    endtask

    // Asserts reset between clock edges and checks outputs before any edge arrives.
    task automatic apply_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_val("rst_empty", 64'(empty), 64'd1);
        check_val("rst_count", 64'(count), 64'd0);
        check_val("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        check_val("rst_alloc_tag", 64'(alloc_tag), 64'd0);
        check_val("rst_commit", {commit_data, 20'd0, commit_tag, commit_rd, commit_reg_write, commit_valid, 5'd0}, 64'd0);
        check_val("rst_q", {30'd0, q1_ready, q2_ready, q1_data | q2_data}, 64'd0);
        mq.delete();
        m_head = 0;
        @(negedge clk);
        alloc_valid = 1'b0; cdb_valid = 1'b0; flush = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_mis = 0; m_head = 0;
        reset = 1'b1;
        alloc_valid = 1'b0; alloc_rd = 5'd0; alloc_writes_rd = 1'b0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = 32'd0;
        q1_tag = '0; q2_tag = '0; flush = 1'b0;
        apply_reset();

        // Basic alloc / complete / commit.
        alloc(5'd5, 1'b1);
        cdb(0, 32'hDEADBEEF);
        idle();
        check_val("t1_commit_data", 64'(commit_data), 64'hDEADBEEF);
        check_val("t1_commit_rw", 64'(commit_reg_write), 64'd1);
        idle();
        check_val("t1_empty", 64'(empty), 64'd1);

        // rd=0 and writes_rd=0 both suppress RegWrite.
        alloc(5'd0, 1'b1);
        cdb(1, 32'h1234);
        idle();
        check_val("t2_rd0_commit", 64'({commit_valid, commit_reg_write}), 64'b10);
        alloc(5'd7, 1'b0);
        cdb(2, 32'h55);
        idle();
        check_val("t2_nowr_commit", 64'({commit_valid, commit_reg_write}), 64'b10);

        // Fill to capacity, reject overflow, then wrap after one retirement.
        step(1'b0, 5'd0, 1'b0, 1'b0, 0, 32'd0, 0, 0, 1'b1);
        for (int i = 0; i < DEPTH; i++) alloc(5'(i + 1), 1'b1);
        alloc(5'd20, 1'b1);
        check_val("t3_full_ready", 64'(alloc_ready), 64'd0);
        check_val("t3_full_count", 64'(count), 64'd16);
        cdb(0, 32'hCAFE0000);
        idle();
        check_val("t3_one_commit", 64'(commit_valid), 64'd1);
        idle();
        check_val("t3_wrap_tag", 64'({alloc_ready, alloc_tag}), 64'h10);
        alloc(5'd9, 1'b1);

        // Out-of-order completion, in-order retirement.
        step(1'b0, 5'd0, 1'b0, 1'b0, 0, 32'd0, 0, 0, 1'b1);
        for (int i = 0; i < 3; i++) alloc(5'(i + 10), 1'b1);
        cdb(2, 32'h22);
        cdb(1, 32'h11);
        cdb(0, 32'h00);
        for (int i = 0; i < 3; i++) begin
            idle();
            check_val("t4_order", 64'({commit_valid, commit_tag}), 64'({1'b1, 4'(i)}));
        end

        // Operand bypass, stored value, unallocated tag.
        step(1'b0, 5'd0, 1'b0, 1'b0, 0, 32'd0, 0, 0, 1'b1);
        for (int i = 0; i < 4; i++) alloc(5'(i + 1), 1'b1);
        step(1'b0, 5'd0, 1'b0, 1'b1, 3, 32'hA5A5A5A5, 3, 9, 1'b0);
        check_val("t5_bypass", 64'({q1_ready, q1_data}), 64'h1A5A5A5A5);
        step(1'b0, 5'd0, 1'b0, 1'b0, 0, 32'd0, 3, 3, 1'b0);
        check_val("t5_stored", 64'({q1_ready, q1_data}), 64'h1A5A5A5A5);
        step(1'b0, 5'd0, 1'b0, 1'b0, 0, 32'd0, 9, 1, 1'b0);
        check_val("t5_unalloc", 64'(q1_ready), 64'd0);

        // Flush together with alloc and CDB discards everything.
        alloc(5'd6, 1'b1);
        step(1'b1, 5'd8, 1'b1, 1'b1, 1, 32'h77, 1, 2, 1'b1);
        idle();
        check_val("t6_flush", 64'({empty, count, commit_valid}), 64'({1'b1, 5'd0, 1'b0}));

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            bit          av;
            bit          cv;
            bit          fl;
            int          ct;
            int          t1;
            int          t2;
            logic [31:0] cd;
            av = ($urandom_range(9) < 6);
            cv = ($urandom_range(9) < 6);
            fl = ($urandom_range(99) < 2);
            if (mq.size() > 0 && $urandom_range(9) < 8) ct = mq[$urandom_range(mq.size() - 1)].tag;
            else ct = $urandom_range(DEPTH - 1);
            t1 = ($urandom_range(3) == 0) ? ct : int'($urandom_range(DEPTH - 1));
            t2 = $urandom_range(DEPTH - 1);
            cd = $urandom;
            step(av, 5'($urandom_range(31)), 1'($urandom_range(1)), cv, ct, cd, t1, t2, fl);
        end

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 3; i++) alloc(5'(i + 2), 1'b1);
        cdb(mq[0].tag, 32'h99);
        step(1'b1, 5'd3, 1'b1, 1'b1, mq[0].tag, 32'h1, mq[0].tag, 0, 1'b0);
        apply_reset();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
